// File: rtl/display_request_scheduler.sv
// Arbitrates image-code requests into the display top, tracks the frame handshake and holds each image on screen.
// Optional build macro SCHED_RR_EN selects round-robin arbitration; otherwise lowest index wins.
//   state        | meaning
//   S_IDLE       | waiting for any request
//   S_ARB        | grant one requester, drive its code
//   S_WAIT_START | code changed, waiting for frame_done to drop
//   S_WAIT_DONE  | frame in progress, waiting for frame_done to rise
//   S_HOLD       | minimum on-screen time, requests ignored
module display_request_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int CODE_W          = 4,
    parameter int IDLE_CODE       = 0,
    parameter int MIN_HOLD_CYCLES = 2000000,
    parameter int START_TIMEOUT   = 4096
) (
    input  logic                          clk_out,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*CODE_W-1:0]     req_code,
    input  logic                          frame_done,
    output logic [CODE_W-1:0]             visua,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          err
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (MIN_HOLD_CYCLES > START_TIMEOUT) ? MIN_HOLD_CYCLES : START_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_START,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   r_visua;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_win_found;
    logic [ID_W-1:0]     w_win_id;
    logic [CODE_W-1:0]   w_win_code;
    logic                w_same_code;

`ifdef SCHED_RR_EN
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] r_rr_ptr;
    int              w_idx;

    // Walk offsets from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_win_code  = '0;
        w_idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_valid[w_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = ID_W'(w_idx);
                w_win_code  = req_code[w_idx*CODE_W +: CODE_W];
            end
        end
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == S_ARB && w_win_found) begin
            r_rr_ptr <= (w_win_id == LAST_ID) ? '0 : w_win_id + ID_W'(1);
        end
    end
`else
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_win_code  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_win_found = 1'b1;
                w_win_id    = ID_W'(i);
                w_win_code  = req_code[i*CODE_W +: CODE_W];
            end
        end
    end
`endif

    assign w_same_code = (w_win_code == r_visua);

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (!w_win_found)    w_state_nxt = S_IDLE;
                else if (w_same_code) w_state_nxt = S_HOLD;
                else                 w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!frame_done)        w_state_nxt = S_WAIT_DONE;
                else if (r_cnt == '0)   w_state_nxt = S_HOLD;
            end
            S_WAIT_DONE: begin
                if (frame_done) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One shared down-counter: start timeout in WAIT_START, on-screen time in HOLD.
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            r_visua    <= CODE_W'(IDLE_CODE);
            r_req_ack  <= '0;
            r_grant_id <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_req_ack <= '0;
            case (r_state)
                S_ARB: begin
                    if (w_win_found) begin
                        r_visua    <= w_win_code;
                        r_req_ack  <= NUM_REQ'(1) << w_win_id;
                        r_grant_id <= w_win_id;
                        r_cnt      <= w_same_code ? HOLD_LOAD : TMO_LOAD;
                    end
                end
                S_WAIT_START: begin
                    if (frame_done) begin
                        if (r_cnt == '0) begin
                            r_err <= 1'b1;
                            r_cnt <= HOLD_LOAD;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (frame_done) r_cnt <= HOLD_LOAD;
                end
                S_HOLD: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign visua    = r_visua;
    assign req_ack  = r_req_ack;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;

endmodule

// File: doc/display_request_scheduler.md
# display_request_scheduler

Sequences requests for new screen images into the ILI9341 frame path. Up to NUM_REQ requesters (pet state machine, sensor handlers, animation ticker) post a 4-bit image code; the block arbitrates, drives the single `visua` code into the display top, tracks the frame handshake via `frame_done`, and enforces a minimum on-screen time before the next change. Sits between the game logic and the display top, in the `clk_out` domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CODE_W, 4, image code width
- IDLE_CODE, 0, code driven after reset
- MIN_HOLD_CYCLES, 2000000, cycles an image stays up after its frame completes
- START_TIMEOUT, 4096, max cycles to wait for frame start

- clk_out  in  1  display-domain clock
- rst  in  1  reset rst, synchronous, active-low; clock clk_out
- req_valid  in  NUM_REQ  request pending, per requester
- req_code  in  NUM_REQ*CODE_W  requested code; requester i uses bits [i*CODE_W +: CODE_W]
- frame_done  in  1  level from the display top: high = no frame in progress
- visua  out  CODE_W  image code to the display top (registered)
- req_ack  out  NUM_REQ  one-hot, one-cycle grant pulse
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky; set on start timeout

## Operation
- States: IDLE, ARB, WAIT_START, WAIT_DONE, HOLD.
- IDLE: any req_valid high -> ARB.
- ARB: pick winner g (see Configuration); visua<=code_g, req_ack[g]<=1, grant_id<=g. If code_g == current visua -> HOLD (the top redraws only on a code change, so no frame is expected); else -> WAIT_START and clear timeout counter.
- WAIT_START: frame_done low -> WAIT_DONE. Counter reaches START_TIMEOUT-1 with frame_done still high -> err<=1, -> HOLD.
- WAIT_DONE: frame_done high -> HOLD, clear hold counter. No timeout (a frame at 240x240 is bounded by the controller).
- HOLD: count MIN_HOLD_CYCLES-1 down to terminal, then -> IDLE. Requests are not sampled.
- Requester rule: keep req_valid and code stable until req_ack; drop valid the cycle after ack. A valid still high after ack is a new request.
- A requester that drops valid before its ack is not granted; no state is kept for it.
- Reset values: visua=IDLE_CODE, req_ack=0, grant_id=0, busy=0, err=0, rr pointer=0, state IDLE. err clears only on reset.
- Reset mid-operation (any state): next edge is in IDLE with reset outputs; an ungranted requester is not acked; a frame already started in the top completes on its own.

## Timing
- req_valid first high at edge k (state IDLE) -> ARB at k+1 -> visua and req_ack valid after edge k+1, i.e. 2 cycles request-to-visua.
- req_ack high exactly one cycle; busy goes high after edge k.
- Minimum request-to-request spacing = 2 + frame time + MIN_HOLD_CYCLES; for an equal code it is 2 + MIN_HOLD_CYCLES.
- Simultaneous valids: exactly one ack per ARB visit; losers wait for the next IDLE pass.
- frame_done already low when entering WAIT_START: transition on the next edge.

## Configuration
- SCHED_RR_EN defined: round robin. The search starts at the rr pointer and wraps modulo NUM_REQ; after a grant, pointer<=g+1 (wraps to 0 after NUM_REQ-1).
- SCHED_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

## Test plan
- Reset, frame_done=1, no requests -> visua=0, busy=0, req_ack=0, err=0 held indefinitely.
- req_valid[1]=1, code 3 at edge k; frame_done dropped 5 cycles later and raised 100 cycles after that -> visua=3 and req_ack=4'b0010 after edge k+1; WAIT_DONE->HOLD; busy drops after MIN_HOLD_CYCLES (set to 10).
- Request of code equal to current visua -> ack after 2 cycles, no WAIT_START, direct HOLD, err stays 0.
- All four valid with codes 1,2,3,4, SCHED_RR_EN defined -> grant order 0,1,2,3 then 0; undefined -> 0 repeatedly while valid[0] is held.
- frame_done held high after a code change, START_TIMEOUT=16 -> err=1 after 16 cycles in WAIT_START, then HOLD, then IDLE.
- rst low while in WAIT_DONE -> next edge: visua=0, busy=0, state IDLE, pending valid[2] not acked until a new ARB.
